tomasulo_rs_multi: RTL and testbench
====================================

# tomasulo_rs_multi

Parametrised reservation station for the Tomasulo pipeline: holds up to N dispatched instructions, snoops CDB_N common-data-bus broadcast ports for outstanding source tags, and issues one ready instruction per granted CDB slot to the attached functional unit. It sits between the dispatch stage and a functional unit. Relative to the single-CDB station it adds:
- multiple CDB snoop ports,
- oldest-first selection,
- a global flush,
- a dispatch back-pressure handshake,
- an occupancy counter.

## Interface
- N, 8: station entries (≥2).
- CDB_N, 2: CDB broadcast ports snooped.
- W, 32: operand data width.
- TAG_W, 4: producer tag width.
- ROBID_W, 4: ROB id width.
- OPC_W, 5; REG_W, 5; IMM_W, 16: opcode, destination register, and immediate widths.

Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dis_vld  in  1  dispatch valid.
- dis_rdy  out  1  station can accept a dispatch (not full).
- dis_opcode / dis_wa / dis_imm / dis_robid / dis_tag  in  OPC_W / REG_W / IMM_W / ROBID_W / TAG_W  instruction fields; dis_tag is the result tag.
- dis_src_busy  in  2  per-source busy flag (1 = value pending).
- dis_src_tag  in  2*TAG_W  source producer tags.
- dis_src_data  in  2*W  source values, used when not busy.
- cdb_vld  in  CDB_N  per-port broadcast valid.
- cdb_tag  in  CDB_N*TAG_W  broadcast tags.
- cdb_wdata  in  CDB_N*W  broadcast data.
- cdb_req  out  1  request for a CDB slot.
- cdb_gnt  in  1  slot granted, same cycle as cdb_req.
- flush  in  1  discard all entries.
- iss_vld_r  out  1  registered issue valid.
- iss_op / iss_wa / iss_imm / iss_robid / iss_tag  out  field widths  issued instruction fields.
- iss_rdata  out  2*W  issued source values.
- occ_r  out  $clog2(N+1)  registered count of valid entries.

## Operation
State per entry:
- vld_r, rdy_r, fields, and two sources of {busy, tag, data}.
- An age matrix, only when the age-order feature below is compiled in.

Allocation:
- On dis_vld & dis_rdy & ~flush, the lowest-index invalid entry is written.
- dis_rdy = ~&vld_r, derived from registered state only. An entry freed in the same cycle is not reusable until the next cycle.
- dis_vld while dis_rdy is low is ignored.

CDB snoop:
- Each cycle, every busy source whose tag matches any valid cdb port captures that port's data and clears busy.
- This applies to both resident entries and the entry being allocated (same-cycle bypass).
- If more than one port matches, the lowest port index wins.

Readiness:
- rdy_r is set when the next-state of both busy flags is 0.
- rdy_r is cleared when the entry issues or is flushed.

Request:
- cdb_req = |(vld_r & rdy_r) & ~flush.

Selection:
- The selected entry is the oldest ready entry (see Configuration).
- On cdb_req & cdb_gnt, the selected entry is copied into the iss_* registers and its vld_r/rdy_r are cleared.
- cdb_gnt without cdb_req is ignored.

Flush:
- Clears all vld_r/rdy_r and occ_r, and drives iss_vld_r to 0 next cycle.
- Has priority over dispatch and grant in the same cycle.

Occupancy:
- occ_r is next-state +1 on allocation, −1 on issue; both together leave it unchanged.
- occ_r never exceeds N.

## Timing
- Reset (async, rst_n low): vld_r=0, rdy_r=0, occ_r=0, iss_vld_r=0, cdb_req=0, dis_rdy=1. iss_* data fields are unreset.
- Dispatch at cycle t with both sources ready → rdy_r at t+1 → cdb_req at t+1 → with gnt at t+1, iss_vld_r=1 at t+2.
- CDB match at cycle t on the last busy source → cdb_req at t+1.
- iss_vld_r is high for exactly one cycle per grant. Back-to-back grants issue one instruction per cycle.
- Full (occ_r=N): dis_rdy=0. A simultaneous issue does not raise dis_rdy until the next cycle.
- Dispatch and issue in the same cycle are independent. A newly allocated entry cannot issue in its allocation cycle.

## Configuration
- TOMASULO_RS_AGE_ORDER_EN defined:
  - An N×N age matrix records dispatch order.
  - Selection picks the ready entry older than all other ready entries.
  - An allocated entry is younger than every valid entry.
- Undefined:
  - No age matrix.
  - Selection is the lowest-index ready entry.

## Test plan
- Reset, then dispatch 1 entry with both sources ready (data 0x11, 0x22), gnt held high → iss_vld_r one cycle at t+2, iss_rdata=0x22_0x11 pair, occ_r 1→0.
- Dispatch with src0 busy tag 3; port 1 broadcasts tag 3 data 0xDEAD one cycle later → cdb_req next cycle, iss_rdata[0]=0xDEAD.
- Dispatch with src1 busy tag 5 in the same cycle as cdb port 0 broadcasts tag 5 data 0xBEEF → entry ready next cycle, iss_rdata[1]=0xBEEF.
- Fill N=8 entries with gnt low → dis_rdy=0, occ_r=8, a 9th dis_vld is dropped; one grant → dis_rdy=1 the following cycle.
- With AGE_ORDER_EN, fill entries 0..3, free entry 0, dispatch A into entry 0, make all ready → issue order is the older three then A. Without the macro, A issues first.
- Flush asserted together with dis_vld and cdb_gnt, 3 entries valid → occ_r=0, iss_vld_r=0 next cycle, no allocation. Drop rst_n mid-operation → all outputs at reset values immediately.

Source files
------------

// File: rtl/tomasulo_rs_multi.sv
// Multi-CDB reservation station with flush, dispatch back-pressure and occupancy count.
// Define TOMASULO_RS_AGE_ORDER_EN for oldest-first issue via an age matrix; otherwise the lowest index issues first.

module tomasulo_rs_multi_entry #(
  parameter int CDB_N = 2,
  parameter int W     = 32,
  parameter int TAG_W = 4,
  parameter int FLD_W = 34
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        alloc,
  input  logic                        issue,
  input  logic [FLD_W-1:0]            dis_fld,
  input  logic [1:0]                  dis_src_busy,
  input  logic [1:0][TAG_W-1:0]       dis_src_tag,
  input  logic [1:0][W-1:0]           dis_src_data,
  input  logic [CDB_N-1:0]            cdb_vld,
  input  logic [CDB_N-1:0][TAG_W-1:0] cdb_tag,
  input  logic [CDB_N-1:0][W-1:0]     cdb_wdata,
  output logic                        vld,
  output logic                        rdy,
  output logic [FLD_W-1:0]            fld,
  output logic [1:0][W-1:0]           src_data
);
  logic                  vld_q, vld_d, rdy_q, rdy_d;
  logic [FLD_W-1:0]      fld_q, fld_d;
  logic [1:0]            busy_q, busy_d, hit;
  logic [1:0][TAG_W-1:0] tag_q, tag_d;
  logic [1:0][W-1:0]     data_q, data_d, cap;

  always_comb begin
    fld_d  = fld_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    data_d = data_q;
    hit    = '0;
    cap    = '0;
    if (alloc) begin
      fld_d  = dis_fld;
      busy_d = dis_src_busy;
      tag_d  = dis_src_tag;
      data_d = dis_src_data;
    end
    // Incoming entry snoops too; scanning high-to-low leaves the lowest matching port in cap.
    if (alloc || vld_q) begin
      for (int s = 0; s < 2; s++) begin
        for (int p = CDB_N-1; p >= 0; p--) begin
          if (busy_d[s] && cdb_vld[p] && cdb_tag[p] == tag_d[s]) begin
            hit[s] = 1'b1;
            cap[s] = cdb_wdata[p];
          end
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (hit[s]) begin
          busy_d[s] = 1'b0;
          data_d[s] = cap[s];
        end
      end
    end
    if (flush || issue) begin
      vld_d = 1'b0;
      rdy_d = 1'b0;
    end else begin
      vld_d = vld_q | alloc;
      rdy_d = (vld_q | alloc) & ~|busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    fld_q  <= fld_d;
    busy_q <= busy_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign vld      = vld_q;
  assign rdy      = rdy_q;
  assign fld      = fld_q;
  assign src_data = data_q;
endmodule

module tomasulo_rs_multi #(
  parameter int N       = 8,
  parameter int CDB_N   = 2,
  parameter int W       = 32,
  parameter int TAG_W   = 4,
  parameter int ROBID_W = 4,
  parameter int OPC_W   = 5,
  parameter int REG_W   = 5,
  parameter int IMM_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dis_vld,
  output logic                     dis_rdy,
  input  logic [OPC_W-1:0]         dis_opcode,
  input  logic [REG_W-1:0]         dis_wa,
  input  logic [IMM_W-1:0]         dis_imm,
  input  logic [ROBID_W-1:0]       dis_robid,
  input  logic [TAG_W-1:0]         dis_tag,
  input  logic [1:0]               dis_src_busy,
  input  logic [2*TAG_W-1:0]       dis_src_tag,
  input  logic [2*W-1:0]           dis_src_data,
  input  logic [CDB_N-1:0]         cdb_vld,
  input  logic [CDB_N*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_N*W-1:0]       cdb_wdata,
  output logic                     cdb_req,
  input  logic                     cdb_gnt,
  input  logic                     flush,
  output logic                     iss_vld_r,
  output logic [OPC_W-1:0]         iss_op,
  output logic [REG_W-1:0]         iss_wa,
  output logic [IMM_W-1:0]         iss_imm,
  output logic [ROBID_W-1:0]       iss_robid,
  output logic [TAG_W-1:0]         iss_tag,
  output logic [2*W-1:0]           iss_rdata,
  output logic [$clog2(N+1)-1:0]   occ_r
);
  localparam int FLD_W = OPC_W + REG_W + IMM_W + ROBID_W + TAG_W;
  localparam int OCC_W = $clog2(N+1);

  logic [N-1:0]            vld, rdy, ready, alloc_oh, sel_oh, issue_oh;
  logic [N-1:0][FLD_W-1:0] e_fld;
  logic [N-1:0][2*W-1:0]   e_data;
  logic [FLD_W-1:0]        dis_fld;
  logic                    alloc_en, grant;

  logic             iss_vld_q, iss_vld_d;
  logic [FLD_W-1:0] iss_fld_q, iss_fld_d;
  logic [2*W-1:0]   iss_data_q, iss_data_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign dis_fld  = {dis_opcode, dis_wa, dis_imm, dis_robid, dis_tag};
  assign dis_rdy  = ~&vld;
  assign alloc_en = dis_vld & dis_rdy & ~flush;
  assign alloc_oh = ~vld & (vld + N'(1)) & {N{alloc_en}};
  assign ready    = vld & rdy;
  assign cdb_req  = |ready & ~flush;
  assign grant    = cdb_req & cdb_gnt;
  assign issue_oh = sel_oh & {N{grant}};

`ifdef TOMASULO_RS_AGE_ORDER_EN
  // age_q[i][j] set: entry i was dispatched before entry j.
  logic [N-1:0][N-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    for (int k = 0; k < N; k++) begin
      if (alloc_oh[k]) begin
        for (int j = 0; j < N; j++) begin
          age_d[k][j] = 1'b0;
          age_d[j][k] = (j != k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N; i++)
      sel_oh[i] = ready[i] & ~|(ready & ~age_q[i] & ~(N'(1) << i));
  end
`else
  assign sel_oh = ready & (~ready + N'(1));
`endif

  for (genvar g = 0; g < N; g++) begin : g_ent
    tomasulo_rs_multi_entry #(
      .CDB_N(CDB_N), .W(W), .TAG_W(TAG_W), .FLD_W(FLD_W)
    ) u_ent (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .alloc        (alloc_oh[g]),
      .issue        (issue_oh[g]),
      .dis_fld      (dis_fld),
      .dis_src_busy (dis_src_busy),
      .dis_src_tag  (dis_src_tag),
      .dis_src_data (dis_src_data),
      .cdb_vld      (cdb_vld),
      .cdb_tag      (cdb_tag),
      .cdb_wdata    (cdb_wdata),
      .vld          (vld[g]),
      .rdy          (rdy[g]),
      .fld          (e_fld[g]),
      .src_data     (e_data[g])
    );
  end

  always_comb begin
    iss_vld_d  = grant;
    iss_fld_d  = iss_fld_q;
    iss_data_d = iss_data_q;
    for (int i = 0; i < N; i++) begin
      if (issue_oh[i]) begin
        iss_fld_d  = e_fld[i];
        iss_data_d = e_data[i];
      end
    end
    if (flush) occ_d = '0;
    else       occ_d = occ_q + OCC_W'(alloc_en) - OCC_W'(grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q <= 1'b0;
      occ_q     <= '0;
    end else begin
      iss_vld_q <= iss_vld_d;
      occ_q     <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    iss_fld_q  <= iss_fld_d;
    iss_data_q <= iss_data_d;
  end

  assign iss_vld_r = iss_vld_q;
  assign occ_r     = occ_q;
  assign iss_rdata = iss_data_q;
  assign {iss_op, iss_wa, iss_imm, iss_robid, iss_tag} = iss_fld_q;
endmodule

// File: tb/tb_tomasulo_rs_multi.sv
// Bench for tomasulo_rs_multi: directed vector table, corner sequences, and random traffic vs a slot/sequence-number model.
module tb_tomasulo_rs_multi;
  localparam int N = 8, CDB_N = 2, W = 32, TAG_W = 4, ROBID_W = 4;
  localparam int OPC_W = 5, REG_W = 5, IMM_W = 16;
  localparam int OCC_W = $clog2(N+1);
  localparam int FLD_W = OPC_W + REG_W + IMM_W + ROBID_W + TAG_W;

  logic clk = 1'b0, rst_n = 1'b0;
  logic dis_vld, dis_rdy, cdb_req, cdb_gnt, flush, iss_vld_r;
  logic [OPC_W-1:0] dis_opcode, iss_op;
  logic [REG_W-1:0] dis_wa, iss_wa;
  logic [IMM_W-1:0] dis_imm, iss_imm;
  logic [ROBID_W-1:0] dis_robid, iss_robid;
  logic [TAG_W-1:0] dis_tag, iss_tag;
  logic [1:0] dis_src_busy;
  logic [2*TAG_W-1:0] dis_src_tag;
  logic [2*W-1:0] dis_src_data, iss_rdata;
  logic [CDB_N-1:0] cdb_vld;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*W-1:0] cdb_wdata;
  logic [OCC_W-1:0] occ_r;

  always #5 clk = ~clk;

  tomasulo_rs_multi #(.N(N), .CDB_N(CDB_N), .W(W), .TAG_W(TAG_W), .ROBID_W(ROBID_W),
                      .OPC_W(OPC_W), .REG_W(REG_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst_n(rst_n), .dis_vld(dis_vld), .dis_rdy(dis_rdy),
    .dis_opcode(dis_opcode), .dis_wa(dis_wa), .dis_imm(dis_imm), .dis_robid(dis_robid),
    .dis_tag(dis_tag), .dis_src_busy(dis_src_busy), .dis_src_tag(dis_src_tag),
    .dis_src_data(dis_src_data), .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .flush(flush), .iss_vld_r(iss_vld_r),
    .iss_op(iss_op), .iss_wa(iss_wa), .iss_imm(iss_imm), .iss_robid(iss_robid),
    .iss_tag(iss_tag), .iss_rdata(iss_rdata), .occ_r(occ_r));

  int n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: slots with a dispatch sequence number for age.
  bit             mv[N];
  bit             mb[N][2];
  logic [TAG_W-1:0] mt[N][2];
  logic [W-1:0]   md[N][2];
  logic [FLD_W-1:0] mf[N];
  int             mseq[N];
  int             seq_ctr;
  bit             m_iss;
  logic [FLD_W-1:0] m_ifld;
  logic [2*W-1:0] m_idata;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mv[i] = 0;
    m_iss = 0;
    seq_ctr = 0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (mv[i]) c++;
    return c;
  endfunction

  function automatic int model_sel();
    int s = -1;
    for (int i = 0; i < N; i++) begin
      if (mv[i] && !mb[i][0] && !mb[i][1]) begin
`ifdef TOMASULO_RS_AGE_ORDER_EN
        if (s < 0 || mseq[i] < mseq[s]) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  function automatic logic [W:0] snoop(input logic busy, input logic [TAG_W-1:0] tag, input logic [W-1:0] data);
    logic b = busy;
    logic [W-1:0] d = data;
    for (int p = 0; p < CDB_N; p++) begin
      if (b && cdb_vld[p] && cdb_tag[p*TAG_W +: TAG_W] == tag) begin
        b = 1'b0;
        d = cdb_wdata[p*W +: W];
      end
    end
    return {b, d};
  endfunction

  task automatic model_step();
    int ai = -1;
    int si;
    logic [W:0] r;
    if (dis_vld && model_count() < N && !flush)
      for (int i = 0; i < N; i++) if (!mv[i] && ai < 0) ai = i;
    si = model_sel();
    m_iss = 0;
    if (flush) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
    end else begin
      if (si >= 0 && cdb_gnt) begin
        m_iss = 1;
        m_ifld = mf[si];
        m_idata = {md[si][1], md[si][0]};
        mv[si] = 0;
      end
      for (int i = 0; i < N; i++)
        if (mv[i])
          for (int s = 0; s < 2; s++) begin
            r = snoop(mb[i][s], mt[i][s], md[i][s]);
            mb[i][s] = r[W];
            md[i][s] = r[W-1:0];
          end
      if (ai >= 0) begin
        mf[ai] = {dis_opcode, dis_wa, dis_imm, dis_robid, dis_tag};
        for (int s = 0; s < 2; s++) begin
          mt[ai][s] = dis_src_tag[s*TAG_W +: TAG_W];
          r = snoop(dis_src_busy[s], mt[ai][s], dis_src_data[s*W +: W]);
          mb[ai][s] = r[W];
          md[ai][s] = r[W-1:0];
        end
        mv[ai] = 1;
        mseq[ai] = seq_ctr++;
      end
    end
  endtask

  task automatic pre_edge();
    #1;
    chk("dis_rdy", dis_rdy, model_count() < N);
    chk("cdb_req", cdb_req, (model_sel() >= 0) && !flush);
  endtask

  task automatic post_edge();
    @(posedge clk);
    model_step();
    #1;
    chk("iss_vld_r", iss_vld_r, m_iss);
    chk("occ_r", occ_r, model_count());
    if (m_iss) begin
      chk("iss_fld", {iss_op, iss_wa, iss_imm, iss_robid, iss_tag}, m_ifld);
      chk("iss_rdata", iss_rdata, m_idata);
    end
  endtask

  task automatic tick();
    pre_edge();
    post_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    dis_vld = 0; dis_opcode = '0; dis_wa = '0; dis_imm = '0; dis_robid = '0; dis_tag = '0;
    dis_src_busy = '0; dis_src_tag = '0; dis_src_data = '0;
    cdb_vld = '0; cdb_tag = '0; cdb_wdata = '0; cdb_gnt = 0; flush = 0;
  endtask

  task automatic do_reset(string nm);
    idle();
    #3 rst_n = 0;
    #1;
    chk({nm, " iss_vld_r"}, iss_vld_r, 0);
    chk({nm, " occ_r"}, occ_r, 0);
    chk({nm, " cdb_req"}, cdb_req, 0);
    chk({nm, " dis_rdy"}, dis_rdy, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic dv; logic [1:0] busy; logic [7:0] stag; logic [63:0] sdata;
    logic [1:0] cv; logic [7:0] ctag; logic [63:0] cdata; logic gnt;
    logic e_req; logic e_iss; logic [3:0] e_occ; logic [63:0] e_rdata;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(logic dv, logic [1:0] busy, logic [7:0] stag, logic [63:0] sdata,
                              logic [1:0] cv, logic [7:0] ctag, logic [63:0] cdata, logic gnt,
                              logic e_req, logic e_iss, logic [3:0] e_occ, logic [63:0] e_rdata);
    vec_t v;
    v.dv = dv; v.busy = busy; v.stag = stag; v.sdata = sdata;
    v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.gnt = gnt;
    v.e_req = e_req; v.e_iss = e_iss; v.e_occ = e_occ; v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROBID_W-1:0] exp_order[4];
    tbl[0]  = mk(1, 2'b00, 8'h00, {32'h22, 32'h11},   2'b00, 8'h00, 64'h0, 1, 0, 0, 1, 64'h0);
    tbl[1]  = mk(0, 2'b00, 8'h00, 64'h0,              2'b00, 8'h00, 64'h0, 1, 1, 1, 0, {32'h22, 32'h11});
    tbl[2]  = mk(0, 2'b00, 8'h00, 64'h0,              2'b00, 8'h00, 64'h0, 1, 0, 0, 0, 64'h0);
    tbl[3]  = mk(1, 2'b01, 8'h03, {32'h5, 32'h0},     2'b00, 8'h00, 64'h0, 1, 0, 0, 1, 64'h0);
    tbl[4]  = mk(0, 2'b00, 8'h00, 64'h0,              2'b10, 8'h30, {32'hDEAD, 32'h0}, 1, 0, 0, 1, 64'h0);
    tbl[5]  = mk(0, 2'b00, 8'h00, 64'h0,              2'b00, 8'h00, 64'h0, 1, 1, 1, 0, {32'h5, 32'hDEAD});
    tbl[6]  = mk(1, 2'b10, 8'h50, {32'h0, 32'h7},     2'b01, 8'h05, {32'h0, 32'hBEEF}, 1, 0, 0, 1, 64'h0);
    tbl[7]  = mk(0, 2'b00, 8'h00, 64'h0,              2'b00, 8'h00, 64'h0, 1, 1, 1, 0, {32'hBEEF, 32'h7});
    tbl[8]  = mk(1, 2'b01, 8'h09, {32'h1, 32'h0},     2'b00, 8'h00, 64'h0, 0, 0, 0, 1, 64'h0);
    tbl[9]  = mk(0, 2'b00, 8'h00, 64'h0,              2'b11, 8'h99, {32'hBBBB, 32'hAAAA}, 0, 0, 0, 1, 64'h0);
    tbl[10] = mk(0, 2'b00, 8'h00, 64'h0,              2'b00, 8'h00, 64'h0, 0, 1, 0, 1, 64'h0);
    tbl[11] = mk(0, 2'b00, 8'h00, 64'h0,              2'b00, 8'h00, 64'h0, 1, 1, 1, 0, {32'h1, 32'hAAAA});
    tbl[12] = mk(1, 2'b11, 8'h42, 64'h0,              2'b01, 8'h07, 64'h0, 1, 0, 0, 1, 64'h0);
    tbl[13] = mk(0, 2'b00, 8'h00, 64'h0,              2'b10, 8'h42, {32'h44, 32'h99}, 1, 0, 0, 1, 64'h0);
    tbl[14] = mk(0, 2'b00, 8'h00, 64'h0,              2'b10, 8'h20, {32'h22, 32'h0}, 1, 0, 0, 1, 64'h0);
    tbl[15] = mk(0, 2'b00, 8'h00, 64'h0,              2'b00, 8'h00, 64'h0, 1, 1, 1, 0, {32'h44, 32'h22});

    idle();
    model_reset();
    #12;
    chk("reset iss_vld_r", iss_vld_r, 0);
    chk("reset occ_r", occ_r, 0);
    chk("reset cdb_req", cdb_req, 0);
    chk("reset dis_rdy", dis_rdy, 1);
    @(negedge clk);
    rst_n = 1;

    for (int k = 0; k < 16; k++) begin
      idle();
      dis_vld = tbl[k].dv; dis_src_busy = tbl[k].busy; dis_src_tag = tbl[k].stag;
      dis_src_data = tbl[k].sdata; dis_robid = ROBID_W'(k);
      cdb_vld = tbl[k].cv; cdb_tag = tbl[k].ctag; cdb_wdata = tbl[k].cdata; cdb_gnt = tbl[k].gnt;
      pre_edge();
      chk($sformatf("vec%0d cdb_req", k), cdb_req, tbl[k].e_req);
      post_edge();
      chk($sformatf("vec%0d iss_vld_r", k), iss_vld_r, tbl[k].e_iss);
      chk($sformatf("vec%0d occ_r", k), occ_r, tbl[k].e_occ);
      if (tbl[k].e_iss) chk($sformatf("vec%0d iss_rdata", k), iss_rdata, tbl[k].e_rdata);
      @(negedge clk);
    end

    // Fill to capacity, drop the overflow dispatch, then free one slot.
    idle();
    for (int k = 0; k < N; k++) begin
      dis_vld = 1; dis_robid = ROBID_W'(k); dis_src_data = {$urandom, $urandom};
      tick();
    end
    chk("full dis_rdy", dis_rdy, 0);
    chk("full occ_r", occ_r, N);
    tick();
    chk("overflow occ_r", occ_r, N);
    cdb_gnt = 1;
    pre_edge();
    chk("full+gnt dis_rdy", dis_rdy, 0);
    post_edge();
    chk("after gnt occ_r", occ_r, N-1);
    chk("after gnt dis_rdy", dis_rdy, 1);
    @(negedge clk);
    do_reset("midop reset");

    // Age-order scenario: free entry 0 and refill it with the youngest instruction.
    idle();
    dis_vld = 1; dis_robid = 0;
    tick();
    dis_src_busy = 2'b01; dis_src_tag = 8'h0A;
    for (int k = 1; k < 4; k++) begin
      dis_robid = ROBID_W'(k);
      tick();
    end
    idle(); cdb_gnt = 1;
    tick();
    chk("age free entry0 robid", iss_robid, 0);
    idle(); dis_vld = 1; dis_src_busy = 2'b01; dis_src_tag = 8'h0A; dis_robid = 9;
    tick();
    idle(); cdb_vld = 2'b01; cdb_tag = 8'h0A; cdb_wdata = {32'h0, 32'h1234};
    tick();
`ifdef TOMASULO_RS_AGE_ORDER_EN
    exp_order = '{4'd1, 4'd2, 4'd3, 4'd9};
`else
    exp_order = '{4'd9, 4'd1, 4'd2, 4'd3};
`endif
    idle(); cdb_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("issue order %0d robid", k), iss_robid, exp_order[k]);
    end

    // Flush alongside dispatch and grant.
    idle(); dis_vld = 1;
    for (int k = 0; k < 4; k++) tick();
    idle(); cdb_gnt = 1;
    tick();
    chk("pre-flush occ_r", occ_r, 3);
    dis_vld = 1; flush = 1;
    pre_edge();
    chk("flush cdb_req", cdb_req, 0);
    post_edge();
    chk("flush occ_r", occ_r, 0);
    chk("flush iss_vld_r", iss_vld_r, 0);
    @(negedge clk);
    idle();
    tick();
    chk("post-flush dis_rdy", dis_rdy, 1);
    chk("post-flush occ_r", occ_r, 0);

    for (int c = 0; c < 3000; c++) begin
      dis_vld = ($urandom_range(0, 99) < 60);
      dis_opcode = OPC_W'($urandom); dis_wa = REG_W'($urandom); dis_imm = IMM_W'($urandom);
      dis_robid = ROBID_W'($urandom); dis_tag = TAG_W'($urandom);
      dis_src_busy = 2'($urandom); dis_src_tag = 8'($urandom);
      dis_src_data = {$urandom, $urandom};
      cdb_vld = 2'($urandom); cdb_tag = 8'($urandom); cdb_wdata = {$urandom, $urandom};
      cdb_gnt = ($urandom_range(0, 99) < 50);
      flush = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
